// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector: serial shift register with a fill-gated pattern matcher
// and a saturating match counter.
module serial_pattern_detector #(
    parameter int WIDTH   = 10,
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in,
    input  logic               enable,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               overlap,
    input  logic               count_clear,
    output logic [WIDTH-1:0]   data,
    output logic               out,
    output logic               match,
    output logic [CNT_W-1:0]   match_count
);
    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
    localparam logic [FW-1:0] ARM  = FW'(PAT_LEN - 1);

    logic [WIDTH-1:0]   data_q, data_d;
    logic [PAT_LEN-1:0] hist_q, hist_d, hist_nxt;
    logic [FW-1:0]      fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, hit;

    always_comb begin
        hist_nxt = {hist_q[PAT_LEN-2:0], in};
        hit      = enable && (fill_q >= ARM) && (hist_nxt == pattern);
        hist_d   = enable ? hist_nxt : hist_q;
        data_d   = enable ? {in, data_q[WIDTH-1:1]} : data_q;
        // Only the fill counter gates detection, so stale history can never hit.
        fill_d   = !enable ? fill_q : (hit && !overlap) ? '0 : (fill_q == FULL) ? fill_q : fill_q + 1'b1;
        cnt_d    = count_clear ? '0 : (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_q  <= {1'b1, {(WIDTH-1){1'b0}}};
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            match_q <= hit;
        end
    end

    assign data        = data_q;
    assign out         = data_q[0];
    assign match       = match_q;
    assign match_count = cnt_q;
endmodule

// File: tb/tb_serial_pattern_detector.sv
// tb_serial_pattern_detector: directed and random stimulus against a queue-based
// reference model; a second instance with CNT_W=2 exercises counter saturation.
module tb_serial_pattern_detector;
    logic       clock = 0, reset_n = 0, in = 0, enable = 0, overlap = 1, count_clear = 0;
    logic [3:0] pattern = 4'b1011;
    logic [9:0] data, data2;
    logic       out, out2, match, match2;
    logic [7:0] count;
    logic [1:0] count2;

    serial_pattern_detector dut (
        .clock(clock), .reset_n(reset_n), .in(in), .enable(enable), .pattern(pattern),
        .overlap(overlap), .count_clear(count_clear), .data(data), .out(out),
        .match(match), .match_count(count)
    );

    serial_pattern_detector #(.WIDTH(10), .PAT_LEN(4), .CNT_W(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .in(in), .enable(enable), .pattern(pattern),
        .overlap(overlap), .count_clear(count_clear), .data(data2), .out(out2),
        .match(match2), .match_count(count2)
    );

    always #5 clock = ~clock;

    int         n_chk = 0, n_fail = 0;
    logic [9:0] m_data = 10'h200;
    bit         q[$];
    int         m_cnt = 0, m_cnt2 = 0;
    logic       m_match = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // The model tracks the bits accepted since the last detection restart; a hit
    // needs PAT_LEN of them whose last PAT_LEN equal the pattern.
    task automatic step(input logic b, input logic e, input logic c, input logic r);
        logic       hit;
        logic [3:0] v;
        in = b; enable = e; count_clear = c; reset_n = r;
        hit = 0;
        if (!r) begin
            m_data = 10'h200;
            q.delete();
            m_cnt = 0;
            m_cnt2 = 0;
        end else begin
            if (e) begin
                m_data = {b, m_data[9:1]};
                q.push_back(b);
                if (q.size() > 4) void'(q.pop_front());
                if (q.size() == 4) begin
                    v = {q[0], q[1], q[2], q[3]};
                    hit = (v == pattern);
                end
                if (hit && !overlap) q.delete();
            end
            m_cnt  = c ? 0 : (hit && m_cnt < 255) ? m_cnt + 1 : m_cnt;
            m_cnt2 = c ? 0 : (hit && m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
        end
        m_match = hit;
        @(posedge clock);
        #1;
        chk("data", 32'(data), 32'(m_data));
        chk("out", 32'(out), 32'(m_data[0]));
        chk("match", 32'(match), 32'(m_match));
        chk("count", 32'(count), 32'(m_cnt));
        chk("match2", 32'(match2), 32'(m_match));
        chk("count2", 32'(count2), 32'(m_cnt2));
    endtask

    task automatic feed(input logic [15:0] s, input int len);
        for (int i = len - 1; i >= 0; i--) step(s[i], 1, 0, 1);
    endtask

    initial begin
        step(0, 1, 1, 0);
        chk("rst_data", 32'(data), 32'h200);
        chk("rst_out", 32'(out), 0);

        feed(16'b110, 3);
        chk("shift3", 32'(data), 32'b0111000000);

        step(0, 0, 0, 0);
        overlap = 1;
        feed(16'b1011011, 7);
        chk("ovl_cnt", 32'(count), 2);

        step(0, 0, 0, 0);
        overlap = 0;
        feed(16'b1011011, 7);
        chk("novl_cnt", 32'(count), 1);

        step(0, 0, 0, 0);
        overlap = 1;
        feed(16'b101, 3);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
        step(1, 1, 0, 1);
        chk("stall_hit", 32'(match), 1);

        step(0, 0, 0, 0);
        feed(16'b1011, 4);
        for (int i = 0; i < 4; i++) feed(16'b011, 3);
        chk("sat_cnt2", 32'(count2), 3);
        chk("sat_cnt", 32'(count), 5);
        feed(16'b01, 2);
        step(1, 1, 1, 1);
        chk("clr_match", 32'(match), 1);
        chk("clr_cnt2", 32'(count2), 0);

        step(0, 0, 0, 0);
        feed(16'b101, 3);
        step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        chk("rst_mid", 32'(match), 0);
        feed(16'b1011, 4);
        chk("rst_after", 32'(match), 1);

        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                pattern = 4'($urandom_range(0, 15));
                overlap = 1'($urandom_range(0, 1));
            end
            step(1'($urandom_range(0, 1)), $urandom_range(0, 9) != 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 79) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
